// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch slice: bus widths, constants
// and fetch-state encodings.
package if_stage_pkg;

  localparam int unsigned AddrBus = 32;
  localparam int unsigned DataBus = 32;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam logic [DataBus-1:0] ZeroWord = '0;
  localparam logic [AddrBus-1:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_stage_pc_next_sel.sv
// Next-PC mux for the fetch stage: flush > pending branch > fresh branch > +4.
module pc_next_sel
  import if_stage_pkg::*;
(
  input  logic               flush_i,
  input  logic [AddrBus-1:0] flush_pc_i,
  input  logic               br_pend_i,
  input  logic [AddrBus-1:0] br_tgt_i,
  input  logic               br_flag_i,
  input  logic [AddrBus-1:0] br_target_i,
  input  logic [AddrBus-1:0] pc_i,
  output logic [AddrBus-1:0] next_pc_o
);

  always_comb begin
    next_pc_o = pc_i + 32'd4;
    if (flush_i)
      next_pc_o = flush_pc_i;
    else if (br_pend_i)
      next_pc_o = br_tgt_i;
    else if (br_flag_i)
      next_pc_o = br_target_i;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one bus request at a time and
// feeds decode through a registered {pc, inst, valid, adel} entry.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [AddrBus-1:0] RESET_PC = if_stage_pkg::RESET_PC,
  parameter logic [DataBus-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_flag,
  input  logic [AddrBus-1:0] br_target,
  input  logic               flush,
  input  logic [AddrBus-1:0] flush_pc,
  output logic               ibus_en,
  output logic [AddrBus-1:0] ibus_addr,
  input  logic               ibus_ack,
  input  logic [DataBus-1:0] ibus_rdata,
  output logic [AddrBus-1:0] id_pc,
  output logic [DataBus-1:0] id_inst,
  output logic               id_valid,
  output logic               id_adel
);

  fetch_state_e       state_q;
  logic [AddrBus-1:0] fetch_pc_q, br_tgt_q, restart_q, hold_pc_q, id_pc_q;
  logic [DataBus-1:0] hold_inst_q, id_inst_q;
  logic               br_pend_q, hold_adel_q, id_valid_q, id_adel_q;

  logic [AddrBus-1:0] next_pc_d;
  logic               misaligned, req_out, complete, consume;
  logic [DataBus-1:0] cmp_inst;

  pc_next_sel u_pc_next_sel (
    .flush_i     (flush),
    .flush_pc_i  (flush_pc),
    .br_pend_i   (br_pend_q),
    .br_tgt_i    (br_tgt_q),
    .br_flag_i   (br_flag),
    .br_target_i (br_target),
    .pc_i        (fetch_pc_q),
    .next_pc_o   (next_pc_d)
  );

  always_comb begin
    misaligned = (fetch_pc_q[1:0] != 2'b00);
    req_out    = ((state_q == FETCH) && !misaligned) || (state_q == DRAIN);
    complete   = (state_q == FETCH) && (misaligned || ibus_ack);
    cmp_inst   = misaligned ? NOP_INST : ibus_rdata;
    consume    = !stall && (complete || (state_q == HOLD));
  end

  assign ibus_en   = req_out && !rst;
  assign ibus_addr = fetch_pc_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;
  assign id_valid  = id_valid_q;
  assign id_adel   = id_adel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      br_pend_q   <= False;
      br_tgt_q    <= '0;
      restart_q   <= '0;
      hold_pc_q   <= '0;
      hold_inst_q <= NOP_INST;
      hold_adel_q <= False;
      id_pc_q     <= ZeroWord;
      id_inst_q   <= NOP_INST;
      id_valid_q  <= False;
      id_adel_q   <= False;
    end else if (flush) begin
      id_valid_q  <= False;
      br_pend_q   <= False;
      hold_adel_q <= False;
      // An issued request cannot be withdrawn; remember the restart address.
      if (req_out && !ibus_ack) begin
        state_q   <= DRAIN;
        restart_q <= flush_pc;
      end else begin
        state_q    <= FETCH;
        fetch_pc_q <= next_pc_d;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (complete) begin
            if (!stall) begin
              id_pc_q    <= fetch_pc_q;
              id_inst_q  <= cmp_inst;
              id_adel_q  <= misaligned;
              id_valid_q <= True;
              fetch_pc_q <= next_pc_d;
            end else begin
              hold_pc_q   <= fetch_pc_q;
              hold_inst_q <= cmp_inst;
              hold_adel_q <= misaligned;
              state_q     <= HOLD;
            end
          end else if (!stall) begin
            id_valid_q <= False;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_pc_q    <= hold_pc_q;
            id_inst_q  <= hold_inst_q;
            id_adel_q  <= hold_adel_q;
            id_valid_q <= True;
            fetch_pc_q <= next_pc_d;
            state_q    <= FETCH;
          end
        end
        DRAIN: begin
          id_valid_q <= False;
          if (ibus_ack) begin
            fetch_pc_q <= restart_q;
            state_q    <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase

      // A pending redirect is consumed by next_pc; a new br_flag that loses
      // to it stays recorded for the following fetch.
      if (consume)
        br_pend_q <= br_pend_q && br_flag;
      else if (br_flag)
        br_pend_q <= True;
      if (br_flag)
        br_tgt_q <= br_target;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, stall, delay slot, flush,
// misaligned target, 32-bit wrap and asynchronous reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br_flag, flush, ibus_ack;
  logic [31:0] br_target, flush_pc, ibus_rdata;
  logic        ibus_en, id_valid, id_adel;
  logic [31:0] ibus_addr, id_pc, id_inst;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  if_stage #(.RESET_PC(32'hBFC0_0000), .NOP_INST(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_flag    (br_flag),
    .br_target  (br_target),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .ibus_en    (ibus_en),
    .ibus_addr  (ibus_addr),
    .ibus_ack   (ibus_ack),
    .ibus_rdata (ibus_rdata),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_valid   (id_valid),
    .id_adel    (id_adel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_flag = 1'b0; flush = 1'b0; ibus_ack = 1'b0;
    br_target = '0; flush_pc = '0; ibus_rdata = '0;

    // Reset held for three cycles
    step(); step(); step();
    check("rst_en",    {31'd0, ibus_en},  32'd0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_adel",  {31'd0, id_adel},  32'd0);
    check("rst_inst",  id_inst,           32'h0000_0000);
    check("rst_pc",    id_pc,             32'h0000_0000);
    rst = 1'b0;
    #1;
    check("first_en",   {31'd0, ibus_en}, 32'd1);
    check("first_addr", ibus_addr,        32'hBFC0_0000);

    // Single-cycle ack stream
    ibus_ack = 1'b1; ibus_rdata = 32'hAED1_0000;
    step();
    check("s0_valid", {31'd0, id_valid}, 32'd1);
    check("s0_pc",    id_pc,             32'hBFC0_0000);
    check("s0_inst",  id_inst,           32'hAED1_0000);
    check("s1_addr",  ibus_addr,         32'hBFC0_0004);

    // Stall on completion of BFC00004, held three cycles
    stall = 1'b1; ibus_rdata = 32'hAED1_0004;
    step();
    ibus_ack = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("hold_en",    {31'd0, ibus_en},  32'd0);
      check("hold_pc",    id_pc,             32'hBFC0_0000);
      check("hold_valid", {31'd0, id_valid}, 32'd1);
      if (i < 2) step();
    end
    stall = 1'b0;
    step();
    check("rel_pc",    id_pc,            32'hBFC0_0004);
    check("rel_inst",  id_inst,          32'hAED1_0004);
    check("rel_en",    {31'd0, ibus_en}, 32'd1);
    check("rel_addr",  ibus_addr,        32'hBFC0_0008);

    // Branch while BFC00008 is outstanding, ack latency 2
    br_flag = 1'b1; br_target = 32'h8000_0100;
    step();
    br_flag = 1'b0;
    check("br_bubble", {31'd0, id_valid}, 32'd0);
    check("br_hold_a", ibus_addr,         32'hBFC0_0008);
    ibus_ack = 1'b1; ibus_rdata = 32'hAED1_0008;
    step();
    check("ds_pc",    id_pc,     32'hBFC0_0008);
    check("ds_inst",  id_inst,   32'hAED1_0008);
    check("tgt_addr", ibus_addr, 32'h8000_0100);

    // Branch coinciding with completion redirects immediately
    ibus_rdata = 32'h9111_0100;
    step();
    check("t0_pc",   id_pc,     32'h8000_0100);
    check("t1_addr", ibus_addr, 32'h8000_0104);
    br_flag = 1'b1; br_target = 32'hBFC0_0010; ibus_rdata = 32'h9111_0104;
    step();
    br_flag = 1'b0;
    check("t1_pc",     id_pc,     32'h8000_0104);
    check("co_br_adr", ibus_addr, 32'hBFC0_0010);

    // Flush while BFC00010 is outstanding; ack three cycles later
    ibus_ack = 1'b0; flush = 1'b1; flush_pc = 32'hBFC0_0380;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("dr_en",    {31'd0, ibus_en},  32'd1);
      check("dr_addr",  ibus_addr,         32'hBFC0_0010);
      check("dr_valid", {31'd0, id_valid}, 32'd0);
      step();
    end
    check("dr_addr3", ibus_addr, 32'hBFC0_0010);
    ibus_ack = 1'b1; ibus_rdata = 32'hDEAD_BEEF;
    step();
    check("dr_discard", {31'd0, id_valid}, 32'd0);
    check("fl_addr",    ibus_addr,         32'hBFC0_0380);
    ibus_rdata = 32'hAED1_0380;
    step();
    check("fl_pc",   id_pc,   32'hBFC0_0380);
    check("fl_inst", id_inst, 32'hAED1_0380);

    // Misaligned branch target
    br_flag = 1'b1; br_target = 32'h8000_0102; ibus_rdata = 32'hAED1_0384;
    step();
    br_flag = 1'b0; ibus_ack = 1'b0;
    #1;
    check("mis_pc0",  id_pc,            32'hBFC0_0384);
    check("mis_addr", ibus_addr,        32'h8000_0102);
    check("mis_en",   {31'd0, ibus_en}, 32'd0);
    br_flag = 1'b1; br_target = 32'hFFFF_FFFC;
    step();
    br_flag = 1'b0;
    check("mis_valid", {31'd0, id_valid}, 32'd1);
    check("mis_adel",  {31'd0, id_adel},  32'd1);
    check("mis_inst",  id_inst,           32'h0000_0000);
    check("mis_pc",    id_pc,             32'h8000_0102);

    // Wrap from FFFFFFFC to 0
    check("wr_addr0", ibus_addr, 32'hFFFF_FFFC);
    ibus_ack = 1'b1; ibus_rdata = 32'hEEEE_FFFC;
    step();
    check("wr_adel", {31'd0, id_adel}, 32'd0);
    check("wr_addr", ibus_addr,        32'h0000_0000);
    br_flag = 1'b1; br_target = 32'hBFC0_0400; ibus_rdata = 32'h1111_0000;
    step();
    br_flag = 1'b0;
    check("wr_pc",   id_pc,     32'h0000_0000);
    check("b4_addr", ibus_addr, 32'hBFC0_0400);

    // Enter HOLD, then assert reset between clock edges
    stall = 1'b1; ibus_rdata = 32'hAED1_0400;
    step();
    ibus_ack = 1'b0;
    #1;
    check("h2_en", {31'd0, ibus_en}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("ar_en",    {31'd0, ibus_en},  32'd0);
    check("ar_valid", {31'd0, id_valid}, 32'd0);
    stall = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("ar_en2",  {31'd0, ibus_en}, 32'd1);
    check("ar_addr", ibus_addr,        32'hBFC0_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage directly upstream of the decode stage. It owns the PC and issues one instruction-bus request at a time. It delivers {pc, inst, valid} through an output register that decode consumes, honouring decode stall. It applies branch redirects after the delay slot, and flush redirects immediately, discarding any in-flight fetch.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset
NOP_INST, 32'h0000_0000, instruction word presented when id_valid=0 or on address error

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  decode cannot accept; output registers hold
br_flag  in  1  decode resolved a taken branch/jump (1-cycle pulse)
br_target  in  32  branch target address
flush  in  1  exception/eret flush (1-cycle pulse); highest priority
flush_pc  in  32  restart address on flush
ibus_en  out  1  request valid; held with ibus_addr until ibus_ack
ibus_addr  out  32  fetch address (word aligned)
ibus_ack  in  1  request complete; ibus_rdata valid this cycle only
ibus_rdata  in  32  fetched instruction
id_pc  out  32  PC of instruction presented to decode
id_inst  out  32  instruction presented to decode
id_valid  out  1  id_pc/id_inst carry a real instruction
id_adel  out  1  presented entry has an instruction address error

Behaviour:
- Reset (async, any cycle, including mid-request): state=FETCH, fetch_pc=RESET_PC, br_pend=0, id_valid=0, id_adel=0, id_inst=NOP_INST, id_pc=0. The first request goes out in the first cycle after rst deasserts. ibus_en=0 while rst=1.
- Registers:
  - fetch_pc: the address of the current request.
  - br_pend, br_tgt: a recorded branch redirect.
  - hold_inst, hold_pc, hold_adel: one-entry buffer.
- States:
  - FETCH: request outstanding.
  - HOLD: a completed fetch is buffered because stall=1; no request is outstanding.
  - DRAIN: a flushed request is still outstanding; its data will be discarded.
- FETCH:
  - ibus_en = (fetch_pc[1:0]==0); ibus_addr = fetch_pc.
  - Completion occurs on ibus_ack, or immediately when misaligned; a misaligned fetch completes with inst=NOP_INST and adel=1, without a bus request.
  - On completion with stall=0: load the output register (valid=1), set fetch_pc=next_pc, stay in FETCH. This gives back-to-back requests at 1 instruction/cycle when ack is single-cycle.
  - On completion with stall=1: load the hold buffer, then go to HOLD.
  - No completion and stall=0: id_valid<=0 (bubble); id_pc/id_inst retain their values.
- HOLD:
  - ibus_en=0.
  - When stall=0: move the hold buffer into the output register, set fetch_pc=next_pc, go to FETCH.
- DRAIN:
  - ibus_en=1 with the old address still held (a request is never withdrawn before ack).
  - On ibus_ack: discard rdata, set fetch_pc=flush target, go to FETCH.
  - id_valid=0 while in DRAIN.
- next_pc = br_pend ? br_tgt : fetch_pc+4, with 32-bit wrap (32'hFFFF_FFFC+4 = 0). Using next_pc clears br_pend.
- Branch and delay slot:
  - br_flag sets br_pend/br_tgt. It does not disturb the fetch in progress (or the buffered one); that fetch is the delay slot and is delivered.
  - The fetch after it uses br_tgt.
  - If br_flag coincides with a completion, br_flag still applies to the next fetch: the completing fetch is the delay slot, so next_pc uses br_target directly.
- Flush, with priority over everything:
  - Clear id_valid, the hold buffer, and br_pend.
  - If a bus request is outstanding and ibus_ack is not in the same cycle: latch flush_pc into a restart register and go to DRAIN.
  - Otherwise: fetch_pc=flush_pc, go to FETCH next cycle.
  - Flush overrides stall.
- stall=1 never changes id_pc, id_inst, id_valid, id_adel.
- Outputs are registered; only ibus_en/ibus_addr derive combinationally from state and fetch_pc.

Decomposition:
- The shared defines header gains:
  - RESET_PC
  - the fetch-state encodings (FETCH=2'd0, HOLD=2'd1, DRAIN=2'd2)
  - reuse of the existing address/data bus width macros and true/false/ZeroWord constants.
- One natural sub-module: pc_next_sel, the combinational next-PC mux (flush > pending branch > br_flag > +4).

Test Plan:
- Reset and stream:
  - Stimulus: rst high for 3 cycles, then ibus_ack=1 every cycle, rdata=addr^32'h1111_0000.
  - Required response: addresses BFC00000, BFC00004, BFC00008 on consecutive cycles; id_valid=1 from cycle 2, with id_pc lagging ibus_addr by 1.
- Stall on completion:
  - Stimulus: stall=1 during the ack for BFC00004, held 3 cycles.
  - Required response: ibus_en=0 during HOLD; id_* unchanged; on release, id_pc=BFC00004, then request BFC00008.
- Branch delay slot:
  - Stimulus: br_flag with target 8000_0100 while BFC00008 is outstanding (ack latency 2).
  - Required response: BFC00008 is delivered; the next request is 8000_0100; BFC0000C is never requested.
- Flush mid-request:
  - Stimulus: flush with flush_pc=BFC00380 while BFC00010 is outstanding; ack 3 cycles later.
  - Required response: ibus_addr stays BFC00010 until ack; that data is discarded (id_valid=0 throughout); the next request is BFC00380.
- Misaligned target:
  - Stimulus: br_target=8000_0102.
  - Required response: no bus request for it; id_valid=1, id_adel=1, id_inst=0, id_pc=8000_0102.
- Async reset mid-request:
  - Stimulus: rst asserted between clock edges while in HOLD.
  - Required response: ibus_en=0 and id_valid=0 immediately; the first request after release is RESET_PC.
